round_key_gen: RTL

ROUND_KEY_GEN -- requirements
Module: round_key_gen

---
 rtl/round_key_gen.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/round_key_gen.sv
// -----------------------------------------------------------------------------
// round_key_gen -- AES-128 key expansion, one round key per clock.
//
// Purpose:
//   On an accepted start the cipher key is presented as round key 0. Every
//   transfer (key_valid, gated by key_ready when back-pressure is enabled)
//   advances to the next FIPS-197 round key, up to round 10. After the round 10
//   key transfers, the block pulses done for one cycle and returns to IDLE.
//
// Handshake:
//   A round key transfers on a rising edge where key_valid=1 and, when
//   ROUND_KEY_BACKPRESSURE_EN is defined, key_ready=1. round_key_out and
//   round_num are stable while key_valid=1 and no transfer happens.
//
// Configuration macro:
//   ROUND_KEY_BACKPRESSURE_EN  defined   -> key_ready gates every transfer
//                              undefined -> key_ready ignored, one round/cycle
//
// Ports:
//   clk            in   1    clock, rising edge
//   rst            in   1    synchronous active-high reset
//   start          in   1    begin expansion of key_in (honoured only in IDLE)
//   key_in         in   128  cipher key, bit 127 = first byte
//   key_ready      in   1    downstream accepts the current round key
//   round_key_out  out  128  current round key
//   round_num      out  4    index of round_key_out, 0..10
//   key_valid      out  1    round_key_out/round_num valid
//   busy           out  1    high from start acceptance through the done cycle
//   done           out  1    one-cycle pulse after round 10 transferred
// -----------------------------------------------------------------------------

// AES forward S-box: multiplicative inverse in GF(2^8) followed by the affine
// transform. Purely combinational.
module aes_sbox (
  input  logic [7:0] a_i,
  output logic [7:0] s_o
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // x^254 = x^-1 for x != 0, and 0 maps to 0 naturally.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] p;
    logic [7:0] r;
    p = x;
    r = 8'h01;
    for (int k = 1; k < 8; k++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  logic [7:0] inv;

  always_comb begin
    inv = gf_inv(a_i);
    s_o = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
              ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end

endmodule

module round_key_gen (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  input  logic         key_ready,
  output logic [127:0] round_key_out,
  output logic [3:0]   round_num,
  output logic         key_valid,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam logic [3:0] LAST_ROUND = 4'd10;

  state_t       state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [3:0]   round_q, round_d;
  logic         valid_q, valid_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;

  logic         ready_eff;
  logic         xfer;

`ifdef ROUND_KEY_BACKPRESSURE_EN
  assign ready_eff = key_ready;
`else
  logic unused_key_ready;
  assign unused_key_ready = key_ready;
  assign ready_eff        = 1'b1;
`endif

  assign xfer = valid_q & ready_eff;

  // ---------------------------------------------------------------------------
  // Next round key from the current one (single cycle).
  // ---------------------------------------------------------------------------
  logic [31:0] w0, w1, w2, w3;
  logic [31:0] rot_w3;
  logic [31:0] sub_w3;
  logic [7:0]  rcon;
  logic [31:0] n0, n1, n2, n3;
  logic [127:0] next_key;

  assign w0     = key_q[127:96];
  assign w1     = key_q[95:64];
  assign w2     = key_q[63:32];
  assign w3     = key_q[31:0];
  assign rot_w3 = {w3[23:0], w3[31:24]};

  aes_sbox u_sbox3 (.a_i(rot_w3[31:24]), .s_o(sub_w3[31:24]));
  aes_sbox u_sbox2 (.a_i(rot_w3[23:16]), .s_o(sub_w3[23:16]));
  aes_sbox u_sbox1 (.a_i(rot_w3[15:8]),  .s_o(sub_w3[15:8]));
  aes_sbox u_sbox0 (.a_i(rot_w3[7:0]),   .s_o(sub_w3[7:0]));

  // Rcon for the round being produced (round_q + 1).
  always_comb begin
    rcon = 8'h00;
    case (round_q)
      4'd0: rcon = 8'h01;
      4'd1: rcon = 8'h02;
      4'd2: rcon = 8'h04;
      4'd3: rcon = 8'h08;
      4'd4: rcon = 8'h10;
      4'd5: rcon = 8'h20;
      4'd6: rcon = 8'h40;
      4'd7: rcon = 8'h80;
      4'd8: rcon = 8'h1b;
      4'd9: rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  assign n0       = w0 ^ sub_w3 ^ {rcon, 24'h000000};
  assign n1       = w1 ^ n0;
  assign n2       = w2 ^ n1;
  assign n3       = w3 ^ n2;
  assign next_key = {n0, n1, n2, n3};

  // ---------------------------------------------------------------------------
  // Control FSM: next-state and register next values.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    round_d = round_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          key_d   = key_in;
          round_d = 4'd0;
          valid_d = 1'b1;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (xfer) begin
          if (round_q == LAST_ROUND) begin
            valid_d = 1'b0;
            done_d  = 1'b1;
            state_d = FIN;
          end else begin
            round_d = round_q + 4'd1;
            key_d   = next_key;
          end
        end
      end
      FIN: begin
        // done_q is high during this state; start is deliberately not looked at.
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      key_q   <= 128'h0;
      round_q <= 4'd0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      round_q <= round_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign round_key_out = key_q;
  assign round_num     = round_q;
  assign key_valid     = valid_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule
